// File: rtl/counter_ctrl_pkg.sv
// Shared opcodes, direction encoding and FSM states for the counter command sequencer.
package counter_ctrl_pkg;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_LOAD_UP = 3'd1;
  localparam logic [2:0] OP_LOAD_DN = 3'd2;
  localparam logic [2:0] OP_RUN_UP  = 3'd3;
  localparam logic [2:0] OP_RUN_DN  = 3'd4;
  localparam logic [2:0] OP_HOLD    = 3'd5;
  localparam logic [2:0] OP_RUN_EXP = 3'd6;
  localparam logic [2:0] OP_RSVD    = 3'd7;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_HOLD,
    ST_RUN_EXP
  } state_e;

endpackage

// File: rtl/counter_cmd_sequencer_sync_fifo.sv
// Small synchronous FIFO with flush; pointers carry one extra wrap bit so full/empty need no flag.
module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (level == (AW+1)'(DEPTH));
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Turns queued commands into cycle-exact enable/preset/pause drive for multifunction_counter.
// Drive outputs are registered; cmd_done and cmd_timeout are combinational so they can follow ctr_expired.
module counter_cmd_sequencer #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [N-1:0] cmd_arg,
  input  logic         abort,
  input  logic         ctr_expired,
  output logic         enable_cnt_up,
  output logic         enable_cnt_dn,
  output logic         new_cntr_preset,
  output logic [N-1:0] new_cntr_preset_value,
  output logic         pause_counting,
  output logic         cmd_done,
  output logic         cmd_timeout,
  output logic         illegal_op,
  output logic         busy
);

  import counter_ctrl_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;

  logic           fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [LW-1:0]  fifo_level;
  logic [2+N:0]   fifo_wdata, fifo_rdata;
  logic [2:0]     head_op;
  logic [N-1:0]   head_arg;

  state_e         state_q, state_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic           dir_q, dir_d;
  logic           up_q, up_d;
  logic           dn_q, dn_d;
  logic           preset_q, preset_d;
  logic [N-1:0]   value_q, value_d;
  logic           pause_q, pause_d;
  logic           illegal_q, illegal_d;
  logic           done_c, timeout_c;

  assign cmd_ready  = !fifo_full && !abort;
  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_wdata = {cmd_op, cmd_arg};
  assign {head_op, head_arg} = fifo_rdata;

  sync_fifo #(
    .WIDTH (3 + N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (fifo_wdata),
    .pop     (fifo_pop),
    .flush   (abort),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // cnt_q holds the active cycles left including the current one; in RUN_EXP a value of 0 means no timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    up_d      = 1'b0;
    dn_d      = 1'b0;
    preset_d  = 1'b0;
    value_d   = value_q;
    pause_d   = 1'b0;
    illegal_d = illegal_q;
    fifo_pop  = 1'b0;
    done_c    = 1'b0;
    timeout_c = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      value_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_LOAD;
            cnt_d    = head_arg;
            case (head_op)
              OP_LOAD_UP: begin
                preset_d = 1'b1;
                value_d  = head_arg;
                dir_d    = DIR_UP;
              end
              OP_LOAD_DN: begin
                preset_d = 1'b1;
                dn_d     = 1'b1;
                value_d  = head_arg;
                dir_d    = DIR_DN;
              end
              OP_RUN_UP, OP_RUN_DN: begin
                dir_d = (head_op == OP_RUN_DN) ? DIR_DN : DIR_UP;
                if (head_arg != '0) begin
                  state_d = ST_RUN;
                  up_d    = (head_op == OP_RUN_UP);
                  dn_d    = (head_op == OP_RUN_DN);
                end
              end
              OP_HOLD: begin
                if (head_arg != '0) begin
                  state_d = ST_HOLD;
                  pause_d = 1'b1;
                end
              end
              OP_RUN_EXP: begin
                state_d = ST_RUN_EXP;
                up_d    = (dir_q == DIR_UP);
                dn_d    = (dir_q == DIR_DN);
              end
              OP_RSVD: illegal_d = 1'b1;
              default: ;
            endcase
          end
        end
        ST_LOAD: begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_RUN, ST_HOLD: begin
          if (cnt_q == N'(1)) begin
            done_c  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q - N'(1);
            up_d    = (state_q == ST_RUN) && (dir_q == DIR_UP);
            dn_d    = (state_q == ST_RUN) && (dir_q == DIR_DN);
            pause_d = (state_q == ST_HOLD);
          end
        end
        ST_RUN_EXP: begin
          if (ctr_expired) begin
            done_c  = 1'b1;
            state_d = ST_IDLE;
          end else if (cnt_q == N'(1)) begin
            done_c    = 1'b1;
            timeout_c = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            if (cnt_q > N'(1)) cnt_d = cnt_q - N'(1);
            up_d = (dir_q == DIR_UP);
            dn_d = (dir_q == DIR_DN);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dir_q     <= DIR_UP;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      preset_q  <= 1'b0;
      value_q   <= '0;
      pause_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      up_q      <= up_d;
      dn_q      <= dn_d;
      preset_q  <= preset_d;
      value_q   <= value_d;
      pause_q   <= pause_d;
      illegal_q <= illegal_d;
    end
  end

  assign enable_cnt_up         = up_q;
  assign enable_cnt_dn         = dn_q;
  assign new_cntr_preset       = preset_q;
  assign new_cntr_preset_value = value_q;
  assign pause_counting        = pause_q;
  assign illegal_op            = illegal_q;
  assign cmd_done              = done_c;
  assign cmd_timeout           = timeout_c;
  assign busy                  = (state_q != ST_IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Bench for counter_cmd_sequencer: directed scenarios plus random traffic against a plan-list reference model.
module tb_counter_cmd_sequencer;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [N-1:0] cmd_arg;
  logic         abort;
  logic         ctr_expired;
  logic         enable_cnt_up;
  logic         enable_cnt_dn;
  logic         new_cntr_preset;
  logic [N-1:0] new_cntr_preset_value;
  logic         pause_counting;
  logic         cmd_done;
  logic         cmd_timeout;
  logic         illegal_op;
  logic         busy;

  int checks;
  int errors;

  counter_cmd_sequencer #(
    .N     (N),
    .DEPTH (DEPTH)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_op                (cmd_op),
    .cmd_arg               (cmd_arg),
    .abort                 (abort),
    .ctr_expired           (ctr_expired),
    .enable_cnt_up         (enable_cnt_up),
    .enable_cnt_dn         (enable_cnt_dn),
    .new_cntr_preset       (new_cntr_preset),
    .new_cntr_preset_value (new_cntr_preset_value),
    .pause_counting        (pause_counting),
    .cmd_done              (cmd_done),
    .cmd_timeout           (cmd_timeout),
    .illegal_op            (illegal_op),
    .busy                  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each popped command expands into a list of per-cycle output records.
  // RUN_EXP is open-ended, so it is a single record that persists until expiry or timeout.
  typedef struct packed {
    logic busy;
    logic up;
    logic dn;
    logic pre;
    logic pause;
    logic done;
    logic exp;
  } rec_t;

  rec_t        cur;
  rec_t        plan[$];
  logic [10:0] mq[$];
  logic [7:0]  m_val;
  logic        m_dir;
  logic        m_illegal;
  int          exp_left;

  function automatic rec_t mkRec(input logic up, input logic dn, input logic pre,
                                 input logic pause, input logic done, input logic exp);
    rec_t r;
    r.busy  = 1'b1;
    r.up    = up;
    r.dn    = dn;
    r.pre   = pre;
    r.pause = pause;
    r.done  = done;
    r.exp   = exp;
    return r;
  endfunction

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic modelReset();
    cur       = '0;
    plan.delete();
    mq.delete();
    m_val     = 8'd0;
    m_dir     = 1'b0;
    m_illegal = 1'b0;
    exp_left  = 0;
  endtask

  task automatic expandCommand(input logic [2:0] op, input logic [7:0] arg);
    int a;
    a = int'(arg);
    case (op)
      3'd1: begin
        plan.push_back(mkRec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        m_val = arg;
        m_dir = 1'b0;
      end
      3'd2: begin
        plan.push_back(mkRec(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
        m_val = arg;
        m_dir = 1'b1;
      end
      3'd3, 3'd4: begin
        m_dir = (op == 3'd4);
        if (a == 0) plan.push_back(mkRec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        else for (int i = 0; i < a; i++)
          plan.push_back(mkRec(op == 3'd3, op == 3'd4, 1'b0, 1'b0, i == a - 1, 1'b0));
      end
      3'd5: begin
        if (a == 0) plan.push_back(mkRec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        else for (int i = 0; i < a; i++)
          plan.push_back(mkRec(1'b0, 1'b0, 1'b0, 1'b1, i == a - 1, 1'b0));
      end
      3'd6: begin
        plan.push_back(mkRec(!m_dir, m_dir, 1'b0, 1'b0, 1'b0, 1'b1));
        exp_left = a;
      end
      3'd7: begin
        plan.push_back(mkRec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        m_illegal = 1'b1;
      end
      default: plan.push_back(mkRec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    endcase
  endtask

  // Advances the model across one clock edge using the inputs that were held during the cycle.
  task automatic modelStep(input logic v, input logic [2:0] op, input logic [7:0] arg,
                           input logic ab, input logic ex);
    logic        can_push;
    logic [10:0] cmd;
    can_push = v && !ab && (mq.size() < DEPTH);
    if (ab) begin
      mq.delete();
      plan.delete();
      cur   = '0;
      m_val = 8'd0;
    end else begin
      if (cur.busy) begin
        if (cur.exp) begin
          if (ex || exp_left == 1) cur = '0;
          else if (exp_left > 1) exp_left--;
        end else if (plan.size() > 0) begin
          cur = plan.pop_front();
        end else begin
          cur = '0;
        end
      end else if (mq.size() > 0) begin
        cmd = mq.pop_front();
        expandCommand(cmd[10:8], cmd[7:0]);
        cur = plan.pop_front();
      end
      if (can_push) mq.push_back({op, arg});
    end
  endtask

  // Drives one cycle of inputs, compares every output mid-cycle, then steps model and DUT together.
  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [7:0] arg,
                               input logic ab, input logic ex);
    logic exp_done;
    logic exp_tmo;
    cmd_valid   = v;
    cmd_op      = op;
    cmd_arg     = arg;
    abort       = ab;
    ctr_expired = ex;
    #1;
    exp_done = ab ? 1'b0 : (cur.exp ? (ex || exp_left == 1) : cur.done);
    exp_tmo  = !ab && cur.exp && !ex && (exp_left == 1);
    checkOutput("enable_cnt_up", 32'(enable_cnt_up), 32'(cur.up));
    checkOutput("enable_cnt_dn", 32'(enable_cnt_dn), 32'(cur.dn));
    checkOutput("new_cntr_preset", 32'(new_cntr_preset), 32'(cur.pre));
    checkOutput("preset_value", 32'(new_cntr_preset_value), 32'(m_val));
    checkOutput("pause_counting", 32'(pause_counting), 32'(cur.pause));
    checkOutput("cmd_done", 32'(cmd_done), 32'(exp_done));
    checkOutput("cmd_timeout", 32'(cmd_timeout), 32'(exp_tmo));
    checkOutput("illegal_op", 32'(illegal_op), 32'(m_illegal));
    checkOutput("cmd_ready", 32'(cmd_ready), 32'(!ab && (mq.size() < DEPTH)));
    checkOutput("busy", 32'(busy), 32'(cur.busy || (mq.size() > 0)));
    modelStep(v, op, arg, ab, ex);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
  endtask

  // Offers a command until the model says it fits, bounded so a stuck FIFO cannot hang the run.
  task automatic pushWait(input logic [2:0] op, input logic [7:0] arg);
    int n;
    n = 0;
    while (mq.size() >= DEPTH && n < 200) begin
      applyStimulus(1'b1, op, arg, 1'b0, 1'b0);
      n++;
    end
    if (n >= 200) checkOutput("push_wait_bound", 32'(n), 32'd0);
    else applyStimulus(1'b1, op, arg, 1'b0, 1'b0);
  endtask

  // Asynchronous reset away from the clock edge: outputs must clear before any edge arrives.
  task automatic resetMidCycle();
    cmd_valid   = 1'b0;
    abort       = 1'b0;
    ctr_expired = 1'b0;
    rst         = 1'b1;
    #1;
    checkOutput("rst_up", 32'(enable_cnt_up), 32'd0);
    checkOutput("rst_dn", 32'(enable_cnt_dn), 32'd0);
    checkOutput("rst_preset", 32'(new_cntr_preset), 32'd0);
    checkOutput("rst_value", 32'(new_cntr_preset_value), 32'd0);
    checkOutput("rst_pause", 32'(pause_counting), 32'd0);
    checkOutput("rst_done", 32'(cmd_done), 32'd0);
    checkOutput("rst_timeout", 32'(cmd_timeout), 32'd0);
    checkOutput("rst_illegal", 32'(illegal_op), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] r_op;
    logic [7:0] r_arg;
    logic       r_valid;
    logic       r_abort;
    logic       r_exp;
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = 3'd0;
    cmd_arg     = 8'd0;
    abort       = 1'b0;
    ctr_expired = 1'b0;
    modelReset();
    #2;
    resetMidCycle();

    // LOAD_DN 20 then RUN_DN 5
    pushWait(3'd2, 8'd20);
    pushWait(3'd4, 8'd5);
    idleCycles(12);

    // LOAD_UP 3 then RUN_EXP with no timeout, ended by an expiry pulse
    pushWait(3'd1, 8'd3);
    pushWait(3'd6, 8'd0);
    idleCycles(5);
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b0, 1'b1);
    idleCycles(4);

    // RUN_EXP with a 4-cycle timeout and no expiry
    pushWait(3'd6, 8'd4);
    idleCycles(10);

    // Fill the FIFO past full while HOLD 10 runs
    pushWait(3'd5, 8'd10);
    idleCycles(2);
    pushWait(3'd3, 8'd2);
    pushWait(3'd0, 8'd0);
    pushWait(3'd1, 8'd7);
    pushWait(3'd4, 8'd1);
    pushWait(3'd5, 8'd0);
    idleCycles(30);

    // Abort a long RUN_UP with two commands queued, then an illegal opcode
    pushWait(3'd3, 8'd50);
    idleCycles(3);
    pushWait(3'd4, 8'd3);
    pushWait(3'd5, 8'd2);
    idleCycles(2);
    applyStimulus(1'b0, 3'd0, 8'd0, 1'b1, 1'b0);
    idleCycles(3);
    pushWait(3'd7, 8'd9);
    idleCycles(4);

    // Reset in the middle of a RUN_UP also clears the sticky illegal flag
    pushWait(3'd3, 8'd20);
    idleCycles(4);
    resetMidCycle();
    idleCycles(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r_op    = 3'($urandom_range(0, 7));
      r_arg   = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      r_valid = ($urandom_range(0, 2) != 0);
      r_abort = ($urandom_range(0, 39) == 0);
      r_exp   = ($urandom_range(0, 5) == 0);
      applyStimulus(r_valid, r_op, r_arg, r_abort, r_exp);
    end
    idleCycles(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
